// File: rtl/input_debouncer.sv
// input_debouncer
// Per-channel button/switch debouncer. Every din bit is brought into the
// clock domain by a two-flop synchroniser. It then has its own stability
// counter, so channels never share timing. dout only follows sync once the
// new level has held for STABLE_CYCLES consecutive cycles.
//
// Build option: define DEBOUNCE_EDGE_EN to get the registered rise / fall /
// any_change pulses. Without it those ports are tied to 0 and no edge
// registers are built. dout timing is the same in both builds.
module input_debouncer #(
    parameter int WIDTH         = 13,
    parameter int STABLE_CYCLES = 100000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    // Terminal count. The counter stops here, so it can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_stable;
    logic [WIDTH-1:0] qualify;
    logic [CNT_W-1:0] cnt [WIDTH];

    // Two-flop synchroniser for the raw asynchronous inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta   <= '0;
            sync_stable <= '0;
        end else begin
            sync_meta   <= din;
            sync_stable <= sync_meta;
        end
    end

    // A channel qualifies when it still differs from dout at the terminal count
    always_comb begin
        qualify = '0;
        for (int i = 0; i < WIDTH; i++) begin
            qualify[i] = (sync_stable[i] != dout[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Independent per-channel stability counters, cleared on match or acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((sync_stable[i] == dout[i]) || qualify[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Accept the synchronised level on every qualifying channel (a flip, since it differs)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= dout ^ qualify;
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    // Registered one-cycle edge pulses, aligned with the dout update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            rise       <= qualify & sync_stable;
            fall       <= qualify & ~sync_stable;
            any_change <= |qualify;
        end
    end
`else
    assign rise       = '0;
    assign fall       = '0;
    assign any_change = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer
// Self-checking bench for input_debouncer at WIDTH=4, STABLE_CYCLES=4.
// The reference model keeps a history of sampled din values. A channel's
// dout takes a new level once the last STABLE_CYCLES synchronised samples
// all show that level. The bench adapts to the DEBOUNCE_EDGE_EN build option.
module tb_input_debouncer;

    localparam int W      = 4;
    localparam int STABLE = 4;
`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any_change;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] dinHist[$];
    logic [W-1:0] syncHist[$];
    logic [W-1:0] expDout;
    logic [W-1:0] expRise;
    logic [W-1:0] expFall;
    logic         expAny;

    // Pulse tallies for the directed scenarios
    int riseCnt[W];
    int fallCnt[W];
    int anyCnt;
    int stepNo;

    input_debouncer #(
        .WIDTH(W),
        .STABLE_CYCLES(STABLE),
        .CNT_W($clog2(STABLE))
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .dout(dout),
        .rise(rise),
        .fall(fall),
        .any_change(any_change)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelClear();
        dinHist.delete();
        syncHist.delete();
        expDout = '0;
        expRise = '0;
        expFall = '0;
        expAny  = 1'b0;
    endtask

    // Advance the model by one rising edge, using the din present at that edge
    task automatic modelEdge();
        logic [W-1:0] syncNow;
        bit allNew;
        syncNow = (dinHist.size() >= 2) ? dinHist[dinHist.size()-2] : '0;
        dinHist.push_back(din);
        if (dinHist.size() > 4) void'(dinHist.pop_front());
        syncHist.push_back(syncNow);
        if (syncHist.size() > STABLE) void'(syncHist.pop_front());
        expRise = '0;
        expFall = '0;
        if (syncHist.size() == STABLE) begin
            for (int i = 0; i < W; i++) begin
                allNew = 1'b1;
                for (int j = 0; j < STABLE; j++) begin
                    if (syncHist[j][i] == expDout[i]) allNew = 1'b0;
                end
                if (allNew) begin
                    if (syncHist[0][i]) expRise[i] = 1'b1;
                    else                expFall[i] = 1'b1;
                    expDout[i] = syncHist[0][i];
                end
            end
        end
        expAny = |(expRise | expFall);
        if (!EDGE_EN) begin
            expRise = '0;
            expFall = '0;
            expAny  = 1'b0;
        end
    endtask

    task automatic clearTally();
        for (int i = 0; i < W; i++) begin
            riseCnt[i] = 0;
            fallCnt[i] = 0;
        end
        anyCnt = 0;
        stepNo = 0;
    endtask

    // Drive din for one cycle (called at negedge) and compare on the next negedge
    task automatic applyStimulus(input logic [W-1:0] newDin);
        din = newDin;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        stepNo++;
        checkOutput("dout", 32'(dout), 32'(expDout));
        checkOutput("rise", 32'(rise), 32'(expRise));
        checkOutput("fall", 32'(fall), 32'(expFall));
        checkOutput("any_change", 32'(any_change), 32'(expAny));
        for (int i = 0; i < W; i++) begin
            riseCnt[i] += int'(rise[i]);
            fallCnt[i] += int'(fall[i]);
        end
        anyCnt += int'(any_change);
    endtask

    // Assert reset at a negedge and check that the outputs clear before any clock edge
    task automatic doReset(input int cycles);
        rst = 1'b1;
        #1;
        checkOutput("reset_dout", 32'(dout), 32'h0);
        checkOutput("reset_rise", 32'(rise), 32'h0);
        checkOutput("reset_fall", 32'(fall), 32'h0);
        checkOutput("reset_any", 32'(any_change), 32'h0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_hold_dout", 32'(dout), 32'h0);
        rst = 1'b0;
        modelClear();
    endtask

    initial begin
        int firstEdge0;
        int firstEdge3;
        int r;
        logic [W-1:0] d;

        rst = 1'b0;
        din = '0;
        modelClear();
        clearTally();
        @(negedge clk);
        doReset(2);

        // Clean press: dout changes at edge 6 with a single rise pulse
        clearTally();
        firstEdge0 = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0001);
            if (dout[0] && firstEdge0 == 0) firstEdge0 = stepNo;
        end
        checkOutput("press_latency", 32'(firstEdge0), 32'd6);
        checkOutput("press_rise_count", 32'(riseCnt[0]), EDGE_EN ? 32'd1 : 32'd0);
        checkOutput("press_any_count", 32'(anyCnt), EDGE_EN ? 32'd1 : 32'd0);

        // Bounce on channel 1: never held long enough to be accepted
        doReset(1);
        clearTally();
        for (int k = 0; k < 8; k++) applyStimulus((k % 4) < 2 ? 4'b0010 : 4'b0000);
        for (int k = 0; k < 8; k++) applyStimulus(4'b0000);
        checkOutput("bounce_dout", 32'(dout), 32'h0);
        checkOutput("bounce_pulses", 32'(riseCnt[1] + fallCnt[1] + anyCnt), 32'd0);

        // Independent channels: ch0 rises at cycle 0, ch3 at cycle 2
        doReset(1);
        clearTally();
        firstEdge0 = 0;
        firstEdge3 = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(k >= 2 ? 4'b1001 : 4'b0001);
            if (dout[0] && firstEdge0 == 0) firstEdge0 = stepNo;
            if (dout[3] && firstEdge3 == 0) firstEdge3 = stepNo;
        end
        checkOutput("indep_edge_ch0", 32'(firstEdge0), 32'd6);
        checkOutput("indep_edge_ch3", 32'(firstEdge3), 32'd8);
        checkOutput("indep_any_count", 32'(anyCnt), EDGE_EN ? 32'd2 : 32'd0);

        // Simultaneous qualification on channels 1 and 3
        doReset(1);
        clearTally();
        for (int k = 0; k < 10; k++) applyStimulus(4'b1010);
        checkOutput("simul_dout", 32'(dout), 32'hA);
        checkOutput("simul_any_count", 32'(anyCnt), EDGE_EN ? 32'd1 : 32'd0);
        checkOutput("simul_rise_ch1", 32'(riseCnt[1]), EDGE_EN ? 32'd1 : 32'd0);

        // Release plus reset mid-count: no fall pulse after release
        for (int k = 0; k < 8; k++) applyStimulus(4'b1111);
        checkOutput("all_high_dout", 32'(dout), 32'hF);
        for (int k = 0; k < 3; k++) applyStimulus(4'b0000);
        doReset(2);
        clearTally();
        for (int k = 0; k < 10; k++) applyStimulus(4'b0000);
        checkOutput("release_fall_count", 32'(fallCnt[0] + fallCnt[1] + fallCnt[2] + fallCnt[3]), 32'd0);

        // Held high through reset: full latency again, then rise
        din = 4'b0101;
        doReset(3);
        clearTally();
        firstEdge0 = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0101);
            if (dout[0] && firstEdge0 == 0) firstEdge0 = stepNo;
        end
        checkOutput("held_reset_latency", 32'(firstEdge0), 32'd6);
        checkOutput("held_reset_rise_ch2", 32'(riseCnt[2]), EDGE_EN ? 32'd1 : 32'd0);

        // Randomised traffic with occasional resets
        d = 4'b0101;
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) d[$urandom_range(0, W-1)] ^= 1'b1;
            if (r == 9 && $urandom_range(0, 29) == 0) begin
                din = d;
                doReset(int'($urandom_range(1, 3)));
            end
            applyStimulus(d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
